// File: rtl/pyramid_pkg.sv
// Shared types and default sizes for the pyramid count sequencer slice.
package pyramid_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_REPEAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pyramid_row_counter.sv
// Count / row-terminal registers for one pyramid row; the sequencer decides
// when to load, clear, step and shrink the row.
module pyramid_row_counter
    import pyramid_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] row_max,
    output logic             row_end
);

    assign row_end = (count == row_max);

    // clear beats load beats step; dec only matters on the wrap cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            row_max <= '0;
        end else if (clear) begin
            count   <= '0;
            row_max <= '0;
        end else if (load) begin
            count   <= '0;
            row_max <= load_val;
        end else if (step) begin
            if (row_end) begin
                count <= '0;
                if (dec) begin
                    row_max <= row_max - 1'b1;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pyramid_sequencer.sv
// Command-driven pyramid sequencer: accepts top/floor/repeats, walks rows
// top..floor for each pass and reports row/pass/sequence completion.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | stepping rows, busy high
//   DONE  | final pass finished, seq_done pulses on exit
module pyramid_sequencer
    import pyramid_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int REPEAT_W = DEF_REPEAT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_top,
    input  logic [WIDTH-1:0]    cmd_floor,
    input  logic [REPEAT_W-1:0] cmd_repeats,
    input  logic                hold,
    input  logic                abort,
    output logic [WIDTH-1:0]    count,
    output logic [WIDTH-1:0]    row_max,
    output logic                busy,
    output logic                row_done,
    output logic                pass_done,
    output logic                seq_done,
    output logic                cmd_err
);

    seq_state_t          state, next_state;
    logic [REPEAT_W-1:0] passes_left, passes_next;
    logic [WIDTH-1:0]    top_q, top_next;
    logic [WIDTH-1:0]    floor_q, floor_next;

    logic                rc_clear, rc_load, rc_step, rc_dec, row_end;
    logic [WIDTH-1:0]    rc_load_val;

    logic                busy_next, row_done_next, pass_done_next;
    logic                seq_done_next, cmd_err_next;

    assign cmd_ready = (state == IDLE) && !reset;

    pyramid_row_counter #(
        .WIDTH (WIDTH)
    ) u_row_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (rc_clear),
        .load     (rc_load),
        .load_val (rc_load_val),
        .step     (rc_step),
        .dec      (rc_dec),
        .count    (count),
        .row_max  (row_max),
        .row_end  (row_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            passes_left <= '0;
            top_q       <= '0;
            floor_q     <= '0;
            busy        <= 1'b0;
            row_done    <= 1'b0;
            pass_done   <= 1'b0;
            seq_done    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= next_state;
            passes_left <= passes_next;
            top_q       <= top_next;
            floor_q     <= floor_next;
            busy        <= busy_next;
            row_done    <= row_done_next;
            pass_done   <= pass_done_next;
            seq_done    <= seq_done_next;
            cmd_err     <= cmd_err_next;
        end
    end

    always_comb begin
        next_state     = state;
        passes_next    = passes_left;
        top_next       = top_q;
        floor_next     = floor_q;
        rc_clear       = 1'b0;
        rc_load        = 1'b0;
        rc_load_val    = top_q;
        rc_step        = 1'b0;
        rc_dec         = 1'b0;
        row_done_next  = 1'b0;
        pass_done_next = 1'b0;
        seq_done_next  = 1'b0;
        cmd_err_next   = 1'b0;

        if (abort) begin
            next_state  = IDLE;
            rc_clear    = 1'b1;
            passes_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_floor > cmd_top) begin
                            cmd_err_next = 1'b1;
                        end else begin
                            next_state  = RUN;
                            rc_load     = 1'b1;
                            rc_load_val = cmd_top;
                            top_next    = cmd_top;
                            floor_next  = cmd_floor;
                            passes_next = (cmd_repeats == '0) ? REPEAT_W'(1) : cmd_repeats;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        rc_step = 1'b1;
                        if (row_end) begin
                            row_done_next = 1'b1;
                            // floor row finished: either the sequence ends or the pass restarts at top
                            if (row_max == floor_q) begin
                                pass_done_next = 1'b1;
                                if (passes_left == REPEAT_W'(1)) begin
                                    next_state = DONE;
                                end else begin
                                    passes_next = passes_left - 1'b1;
                                    rc_load     = 1'b1;
                                end
                            end else begin
                                rc_dec = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    next_state    = IDLE;
                    seq_done_next = 1'b1;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end

        busy_next = (next_state == RUN);
    end

endmodule

// File: tb/tb_pyramid_sequencer.sv
// Directed bench for pyramid_sequencer with hand-computed cycle-by-cycle expectations.
module tb_pyramid_sequencer;

    localparam int WIDTH    = 4;
    localparam int REPEAT_W = 4;

    logic                clk, reset;
    logic                cmd_valid, cmd_ready, hold, abort;
    logic [WIDTH-1:0]    cmd_top, cmd_floor, count, row_max;
    logic [REPEAT_W-1:0] cmd_repeats;
    logic                busy, row_done, pass_done, seq_done, cmd_err;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_seen, pd_seen;

    // top=3 floor=1 rep=1, observed after the accepting edge
    int t1_c  [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    int t1_rm [10] = '{3, 3, 3, 3, 2, 2, 2, 1, 1, 1};
    int t1_rd [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    // top=3 floor=0 rep=0 with hold over two edges at count=2
    int t4_c  [13] = '{0, 1, 2, 2, 2, 3, 0, 1, 2, 0, 1, 0, 0};
    int t4_rm [13] = '{3, 3, 3, 3, 3, 3, 2, 2, 2, 1, 1, 0, 0};
    int t4_rd [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1};

    pyramid_sequencer #(
        .WIDTH    (WIDTH),
        .REPEAT_W (REPEAT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_top     (cmd_top),
        .cmd_floor   (cmd_floor),
        .cmd_repeats (cmd_repeats),
        .hold        (hold),
        .abort       (abort),
        .count       (count),
        .row_max     (row_max),
        .busy        (busy),
        .row_done    (row_done),
        .pass_done   (pass_done),
        .seq_done    (seq_done),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_cyc(input string tag, input int i, input int c, input int rm,
                           input int rd, input int pd, input int sd, input int bz);
        chk($sformatf("%s[%0d].count", tag, i),     32'(count),     32'(c));
        chk($sformatf("%s[%0d].row_max", tag, i),   32'(row_max),   32'(rm));
        chk($sformatf("%s[%0d].row_done", tag, i),  32'(row_done),  32'(rd));
        chk($sformatf("%s[%0d].pass_done", tag, i), 32'(pass_done), 32'(pd));
        chk($sformatf("%s[%0d].seq_done", tag, i),  32'(seq_done),  32'(sd));
        chk($sformatf("%s[%0d].busy", tag, i),      32'(busy),      32'(bz));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input int t, input int f, input int r);
        cmd_valid   = 1'b1;
        cmd_top     = WIDTH'(t);
        cmd_floor   = WIDTH'(f);
        cmd_repeats = REPEAT_W'(r);
        step();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0;
        cmd_top = '0; cmd_floor = '0; cmd_repeats = '0;

        step();
        chk_cyc("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset.cmd_err",   32'(cmd_err),   32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset.cmd_ready", 32'(cmd_ready), 32'd1);
        step();

        // basic pass, top=3 floor=1
        send(3, 1, 1);
        rd_seen = 0; pd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            chk_cyc("t1", i, t1_c[i], t1_rm[i], t1_rd[i], (i == 9) ? 1 : 0, 0, (i < 9) ? 1 : 0);
            chk($sformatf("t1[%0d].cmd_ready", i), 32'(cmd_ready), 32'd0);
            rd_seen += int'(row_done);
            pd_seen += int'(pass_done);
            step();
        end
        chk("t1.rows", 32'(rd_seen), 32'd3);
        chk("t1.passes", 32'(pd_seen), 32'd1);
        chk_cyc("t1", 10, 0, 1, 0, 0, 1, 0);
        chk("t1.end.cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("t1.seq_done_once", 32'(seq_done), 32'd0);

        // rejected command, floor > top
        send(2, 5, 1);
        chk("t2.cmd_err",   32'(cmd_err),   32'd1);
        chk("t2.busy",      32'(busy),      32'd0);
        chk("t2.cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("t2.cmd_err_pulse", 32'(cmd_err),   32'd0);
        chk("t2.busy_after",    32'(busy),      32'd0);
        chk("t2.ready_after",   32'(cmd_ready), 32'd1);

        // single-cycle rows, two passes
        send(0, 0, 2);
        chk_cyc("t3", 0, 0, 0, 0, 0, 0, 1);
        step();
        chk_cyc("t3", 1, 0, 0, 1, 1, 0, 1);
        step();
        chk_cyc("t3", 2, 0, 0, 1, 1, 0, 0);
        step();
        chk_cyc("t3", 3, 0, 0, 0, 0, 1, 0);
        chk("t3.cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("t3.seq_done_once", 32'(seq_done), 32'd0);

        // repeats=0 acts as one pass; hold freezes count at 2 for two edges
        send(3, 0, 0);
        for (int i = 0; i < 13; i++) begin
            chk_cyc("t4", i, t4_c[i], t4_rm[i], t4_rd[i], (i == 12) ? 1 : 0, 0, (i < 12) ? 1 : 0);
            hold = (i == 2 || i == 3);
            step();
        end
        chk_cyc("t4", 13, 0, 0, 0, 0, 1, 0);
        step();
        chk("t4.seq_done_once", 32'(seq_done), 32'd0);

        // abort at count 1 of the second row
        send(3, 0, 1);
        for (int i = 0; i < 5; i++) step();
        chk("t5.pre.count",   32'(count),   32'd1);
        chk("t5.pre.row_max", 32'(row_max), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_cyc("t5.abort", 0, 0, 0, 0, 0, 0, 0);
        chk("t5.abort.cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        chk_cyc("t5.abort", 1, 0, 0, 0, 0, 0, 0);
        send(1, 1, 1);
        chk_cyc("t5.next", 0, 0, 1, 0, 0, 0, 1);
        step();
        chk_cyc("t5.next", 1, 1, 1, 0, 0, 0, 1);
        step();
        chk_cyc("t5.next", 2, 0, 1, 1, 1, 0, 0);
        step();
        chk_cyc("t5.next", 3, 0, 1, 0, 0, 1, 0);
        step();

        // asynchronous reset while a row_done pulse is showing
        send(3, 1, 3);
        for (int i = 0; i < 4; i++) step();
        chk("t6.pre.row_done", 32'(row_done), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_cyc("t6.reset", 0, 0, 0, 0, 0, 0, 0);
        chk("t6.reset.cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6.idle.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6.idle.busy",      32'(busy),      32'd0);
        send(1, 0, 1);
        chk_cyc("t6.restart", 0, 0, 1, 0, 0, 0, 1);
        step();
        chk_cyc("t6.restart", 1, 1, 1, 0, 0, 0, 1);
        step();
        chk_cyc("t6.restart", 2, 0, 0, 1, 0, 0, 1);
        step();
        chk_cyc("t6.restart", 3, 0, 0, 1, 1, 0, 0);
        step();
        chk_cyc("t6.restart", 4, 0, 0, 0, 0, 1, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
